// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier, 8x8 signed -> 16-bit signed product.
// The add/subtract step is done by an external 8-bit ripple-carry unit. This
// block drives that unit's operands and control, and it captures the unit's
// sum and carry. One Booth iteration takes an ADD cycle and a SHIFT cycle.
module booth_seq_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [7:0]  adder_a,
  output logic [7:0]  adder_b,
  output logic        adder_cin,
  output logic        adder_enable,
  input  logic [7:0]  adder_sum,
  input  logic        adder_cout
);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  a_reg;
  logic        a_ext;
  logic [7:0]  q_reg;
  logic        q_1;
  logic [7:0]  m_reg;
  logic [2:0]  cnt;
  logic [1:0]  booth_bits;

  assign booth_bits = {q_reg[0], q_1};
  assign adder_a    = a_reg;
  assign adder_b    = m_reg;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: 8 ADD/SHIFT pairs, then a single DONE cycle
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ADD;
      ADD:     next_state = SHIFT;
      SHIFT:   next_state = (cnt == 3'd7) ? DONE : ADD;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: status flags and adder control from the Booth bit pair
  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    adder_enable = 1'b0;
    adder_cin    = 1'b0;
    if (state == ADD) begin
      adder_enable = (booth_bits == 2'b01) || (booth_bits == 2'b10);
      adder_cin    = (booth_bits == 2'b10);
    end
  end

  // Datapath: operand load, accumulate, arithmetic shift, product capture.
  // The 9th accumulator bit is a7 ^ b_eff7 ^ cout, where b_eff7 = M[7] ^ cin.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= 8'd0;
      a_ext   <= 1'b0;
      q_reg   <= 8'd0;
      q_1     <= 1'b0;
      m_reg   <= 8'd0;
      cnt     <= 3'd0;
      product <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= x;
            q_reg <= y;
            a_reg <= 8'd0;
            a_ext <= 1'b0;
            q_1   <= 1'b0;
            cnt   <= 3'd0;
          end
        end
        ADD: begin
          if (adder_enable) begin
            a_reg <= adder_sum;
            a_ext <= a_reg[7] ^ m_reg[7] ^ adder_cin ^ adder_cout;
          end
        end
        SHIFT: begin
          a_reg <= {a_ext, a_reg[7:1]};
          q_reg <= {a_reg[0], q_reg[7:1]};
          q_1   <= q_reg[0];
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) product <= {a_ext, a_reg, q_reg[7:1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier. It models the external 8-bit
// add/subtract unit and keeps a scoreboard of expected signed products.
module tb_booth_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [7:0]  adder_a;
  logic [7:0]  adder_b;
  logic        adder_cin;
  logic        adder_enable;
  logic [7:0]  adder_sum;
  logic        adder_cout;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  booth_seq_multiplier dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .product(product),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_enable(adder_enable), .adder_sum(adder_sum), .adder_cout(adder_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ripple-carry add/subtract unit: cin=1 subtracts, enable=0 forces zeros
  always_comb begin
    logic [8:0] s;
    s = {1'b0, adder_a} + {1'b0, (adder_cin ? ~adder_b : adder_b)} + {8'd0, adder_cin};
    adder_sum  = adder_enable ? s[7:0] : 8'd0;
    adder_cout = adder_enable ? s[8]   : 1'b0;
  end

  function automatic logic [15:0] ref_mul(input logic [7:0] xv, input logic [7:0] yv);
    int xi;
    int yi;
    int p;
    xi = $signed(xv);
    yi = $signed(yv);
    p  = xi * yi;
    return p[15:0];
  endfunction

  // Drive a one-cycle start; returns at the negedge after the accept edge
  task automatic start_op(input logic [7:0] xv, input logic [7:0] yv, input bit expect_result);
    @(negedge clk);
    x = xv;
    y = yv;
    start = 1'b1;
    if (expect_result) exp_q.push_back(ref_mul(xv, yv));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for the done pulse, counting negedges
  task automatic wait_for_done(output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    x = 8'h5A;
    y = 8'hA5;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, adder_enable, adder_cin} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got busy/done/en/cin=%b expected 0000", {busy, done, adder_enable, adder_cin});
    end
    checks++;
    if (product !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_product: got %h expected 0000", product);
    end
    checks++;
    if ({adder_a, adder_b} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_adder_ops: got a=%h b=%h expected 00 00", adder_a, adder_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_timing();
    logic [7:0] yv;
    logic [15:0] e;
    logic q0;
    logic qm;
    int it;
    yv = 8'd5;
    start_op(8'd3, yv, 1'b1);
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL basic_busy c=%0d: got %b expected 1", c, busy);
      end
      checks++;
      if (done !== (c == 16)) begin
        errors++;
        $display("[TB] FAIL basic_done c=%0d: got %b expected %b", c, done, (c == 16));
      end
      if (c < 16 && (c % 2) == 0) begin
        it = c / 2;
        q0 = yv[it];
        qm = (it == 0) ? 1'b0 : yv[it-1];
        checks++;
        if ({adder_enable, adder_cin} !== {q0 ^ qm, q0 & ~qm}) begin
          errors++;
          $display("[TB] FAIL basic_adder_ctl iter=%0d: got en/cin=%b%b expected %b%b", it, adder_enable, adder_cin, q0 ^ qm, q0 & ~qm);
        end
      end else if (c < 16) begin
        checks++;
        if (adder_enable !== 1'b0) begin
          errors++;
          $display("[TB] FAIL basic_shift_en c=%0d: got %b expected 0", c, adder_enable);
        end
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (product !== e) begin
      errors++;
      $display("[TB] FAIL basic_product: got %h expected %h", product, e);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00 || product !== 16'h000F) begin
      errors++;
      $display("[TB] FAIL basic_after: got busy/done=%b%b product=%h expected 00 000f", busy, done, product);
    end
  endtask

  task automatic run_table_op(input string name, input logic [7:0] xv, input logic [7:0] yv);
    bit seen;
    int cycles;
    logic [15:0] e;
    start_op(xv, yv, 1'b1);
    wait_for_done(seen, cycles);
    e = exp_q.pop_front();
    checks++;
    if (!seen || cycles != 16) begin
      errors++;
      $display("[TB] FAIL %s_latency: got seen=%0d cycles=%0d expected 1 16", name, seen, cycles);
    end
    checks++;
    if (product !== e) begin
      errors++;
      $display("[TB] FAIL %s_product: got %h expected %h", name, product, e);
    end
  endtask

  task automatic test_corner_products();
    run_table_op("neg7x6",   8'hF9, 8'h06);
    run_table_op("6xneg7",   8'h06, 8'hF9);
    run_table_op("min_x_min", 8'h80, 8'h80);
    run_table_op("zero_x_m1", 8'h00, 8'hFF);
    run_table_op("max_x_max", 8'h7F, 8'h7F);
    run_table_op("m1_x_m1",  8'hFF, 8'hFF);
    run_table_op("min_x_max", 8'h80, 8'h7F);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_table_op("random", 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_ignored_start();
    bit seen;
    int cycles;
    logic [15:0] e;
    start_op(8'd3, 8'd5, 1'b1);
    repeat (4) @(negedge clk);
    x = 8'd9;
    y = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for_done(seen, cycles);
    e = exp_q.pop_front();
    checks++;
    if (!seen || (cycles + 5) != 16) begin
      errors++;
      $display("[TB] FAIL ignored_latency: got seen=%0d cycles=%0d expected 1 16", seen, cycles + 5);
    end
    checks++;
    if (product !== e) begin
      errors++;
      $display("[TB] FAIL ignored_product: got %h expected %h", product, e);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || product !== 16'h000F) begin
      errors++;
      $display("[TB] FAIL ignored_no_restart: got busy=%b product=%h expected 0 000f", busy, product);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int cycles;
    logic [15:0] e;
    @(negedge clk);
    x = 8'd3;
    y = 8'd5;
    start = 1'b1;
    exp_q.push_back(ref_mul(8'd3, 8'd5));
    @(negedge clk);
    x = 8'hF6;
    y = 8'h0D;
    exp_q.push_back(ref_mul(8'hF6, 8'h0D));
    wait_for_done(seen, cycles);
    e = exp_q.pop_front();
    checks++;
    if (!seen || cycles != 16 || product !== e) begin
      errors++;
      $display("[TB] FAIL b2b_first: got seen=%0d cycles=%0d product=%h expected 1 16 %h", seen, cycles, product, e);
    end
    wait_for_done(seen, cycles);
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!seen || cycles != 18) begin
      errors++;
      $display("[TB] FAIL b2b_spacing: got seen=%0d cycles=%0d expected 1 18", seen, cycles);
    end
    checks++;
    if (product !== e) begin
      errors++;
      $display("[TB] FAIL b2b_second_product: got %h expected %h", product, e);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    int cycles;
    bit stray_done;
    logic [15:0] e;
    start_op(8'd12, 8'hFD, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, adder_enable} !== 3'b000 || product !== 16'h0000 || adder_a !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midreset_state: got busy/done/en=%b%b%b product=%h a=%h expected 000 0000 00", busy, done, adder_enable, product, adder_a);
    end
    rst = 1'b0;
    stray_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray_done = 1'b1;
    end
    checks++;
    if (stray_done) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: got activity=1 expected 0");
    end
    start_op(8'd12, 8'hFD, 1'b1);
    wait_for_done(seen, cycles);
    e = exp_q.pop_front();
    checks++;
    if (!seen || cycles != 16 || product !== e) begin
      errors++;
      $display("[TB] FAIL midreset_fresh: got seen=%0d cycles=%0d product=%h expected 1 16 %h", seen, cycles, product, e);
    end
  endtask

  initial begin
    test_reset();
    test_basic_timing();
    test_corner_products();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
